noc_mux_arbiter: RTL and testbench



---
 rtl/noc_pkg.sv | 22 ++
 rtl/noc_rr_arbiter.sv | 40 ++++
 rtl/noc_mux_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_noc_mux_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared NoC definitions. Holds the flit header field bounds
//                and the packet arbiter state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package noc_pkg;

    // Header field bounds inside a flit
    localparam int CLASS_MSB = 26;
    localparam int CLASS_LSB = 24;
    localparam int DEST_MSB  = 23;
    localparam int DEST_LSB  = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/noc_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : noc_rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first set req
//                bit found searching upward from the position after ptr,
//                wrapping around.
//  Ports       : req   [N]  request vector
//                ptr   [N]  one-hot, last-served position
//                grant [N]  one-hot winner (0 when no request)
//  Revision    : 1.0  initial release
// ============================================================================
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] grant
);

    localparam logic [N-1:0] c_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] w_above;
    logic [N-1:0] w_req_hi;

    always_comb begin
        // Positions strictly above the last-served one.
        w_above  = ~(ptr - c_ONE) & ~ptr;
        w_req_hi = req & w_above;
        // x & -x isolates the lowest set bit; fall back to a full scan on wrap.
        if (|w_req_hi) begin
            grant = w_req_hi & (~w_req_hi + c_ONE);
        end else begin
            grant = req & (~req + c_ONE);
        end
    end

endmodule : noc_rr_arbiter
`default_nettype wire

// File: rtl/noc_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : noc_mux_arbiter
//  Description : Packet-level N:1 flit merger with round-robin fairness
//                between packets. A packet (first flit through last) is
//                never interleaved with another.
//  Ports       : clk, rst (sync, active-high)
//                in_flit/in_last/in_valid/in_ready  per-channel input links
//                out_flit/out_last/out_valid/out_ready merged output link
//                grant  one-hot current owner
//  Options     : NOC_MUX_ARBITER_OUT_REG_EN - inserts a 2-entry skid slice
//                on the output link (+1 cycle latency, full throughput).
//  Revision    : 1.0  initial release
// ============================================================================
module noc_mux_arbiter
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int CHANNELS   = 7
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit,
    input  logic [CHANNELS-1:0]                 in_last,
    input  logic [CHANNELS-1:0]                 in_valid,
    output logic [CHANNELS-1:0]                 in_ready,
    output logic [FLIT_WIDTH-1:0]               out_flit,
    output logic                                out_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [CHANNELS-1:0]                 grant
);

    // Pointer starts on the top channel so channel 0 has first priority.
    localparam logic [CHANNELS-1:0] c_PTR_RST = {1'b1, {(CHANNELS-1){1'b0}}};

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [CHANNELS-1:0]     r_owner;
    logic [CHANNELS-1:0]     w_owner_nxt;
    logic [CHANNELS-1:0]     r_ptr;
    logic [CHANNELS-1:0]     w_ptr_nxt;
    logic                    r_gap;
    logic                    w_gap_nxt;

    logic [CHANNELS-1:0]     w_winner;
    logic [CHANNELS-1:0]     w_grant;
    logic [FLIT_WIDTH-1:0]   w_sel_flit;
    logic                    w_sel_valid;
    logic                    w_sel_last;
    logic                    w_arb_ready;
    logic                    w_fire;

    noc_rr_arbiter #(
        .N     (CHANNELS)
    ) u_rr_arbiter (
        .req   (in_valid),
        .ptr   (r_ptr),
        .grant (w_winner)
    );

    // Owner while BUSY; the live winner while IDLE, except in the single
    // re-arbitration cycle that follows the end of a multi-flit packet.
    always_comb begin
        w_grant = '0;
        if (!rst) begin
            if (r_state == BUSY) begin
                w_grant = r_owner;
            end else if (!r_gap) begin
                w_grant = w_winner;
            end
        end
    end

    always_comb begin
        w_sel_flit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant[i]) begin
                w_sel_flit = w_sel_flit | in_flit[i];
            end
        end
    end

    assign w_sel_valid = |(w_grant & in_valid);
    assign w_sel_last  = |(w_grant & in_last);
    assign w_fire      = w_sel_valid & w_arb_ready;
    assign in_ready    = w_grant & {CHANNELS{w_arb_ready}};
    assign grant       = w_grant;

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= c_PTR_RST;
            r_gap   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_gap_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sel_valid) begin
                    if (w_fire && w_sel_last) begin
                        // Single-flit packet completes without locking.
                        w_ptr_nxt = w_grant;
                    end else begin
                        // Lock the grant so the link stays stable under
                        // backpressure and the packet is not interleaved.
                        w_state_nxt = BUSY;
                        w_owner_nxt = w_grant;
                    end
                end
            end
            BUSY: begin
                if (w_fire && w_sel_last) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = r_owner;
                    w_owner_nxt = '0;
                    w_gap_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_owner_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output link
    // ------------------------------------------------------------------
`ifdef NOC_MUX_ARBITER_OUT_REG_EN
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [FLIT_WIDTH-1:0] r_out_flit;
    logic                  r_skid_valid;
    logic                  r_skid_last;
    logic [FLIT_WIDTH-1:0] r_skid_flit;

    // Accept only while the skid entry is free, so out_ready never reaches
    // in_ready combinationally.
    assign w_arb_ready = ~r_skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_flit   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
            r_skid_flit  <= '0;
        end else if (!r_out_valid || out_ready) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_flit   <= r_skid_flit;
                r_out_last   <= r_skid_last;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid  <= w_fire;
                r_out_flit   <= w_fire ? w_sel_flit : '0;
                r_out_last   <= w_fire & w_sel_last;
            end
        end else if (w_fire) begin
            // Output stalled: park the accepted flit in the skid entry.
            r_skid_valid <= 1'b1;
            r_skid_flit  <= w_sel_flit;
            r_skid_last  <= w_sel_last;
        end
    end

    assign out_valid = r_out_valid;
    assign out_flit  = r_out_flit;
    assign out_last  = r_out_last;
`else
    assign w_arb_ready = out_ready;
    assign out_valid   = w_sel_valid;
    assign out_flit    = w_sel_valid ? w_sel_flit : '0;
    assign out_last    = w_sel_valid & w_sel_last;
`endif

endmodule : noc_mux_arbiter
`default_nettype wire

// File: tb/tb_noc_mux_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_noc_mux_arbiter
//  Description : Self-checking bench for noc_mux_arbiter (CHANNELS=3).
//                Per-channel packet sources, expected flits queued in
//                arbitration order and compared as they leave out_*.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_noc_mux_arbiter;

    localparam int FW = 32;
    localparam int CH = 3;
`ifdef NOC_MUX_ARBITER_OUT_REG_EN
    localparam logic FIRST_VALID = 1'b0;
`else
    localparam logic FIRST_VALID = 1'b1;
`endif

    typedef struct {
        int            ch;
        logic [FW-1:0] flit;
        logic          last;
    } src_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0][FW-1:0] in_flit;
    logic [CH-1:0]       in_last;
    logic [CH-1:0]       in_valid;
    logic [CH-1:0]       in_ready;
    logic [FW-1:0]       out_flit;
    logic                out_last;
    logic                out_valid;
    logic                out_ready;
    logic [CH-1:0]       grant;

    int   checks   = 0;
    int   failures = 0;
    bit   sb_en    = 1'b0;
    src_t src_q[$];
    logic [FW:0] exp_q[$];
    logic [FW:0] mon_e;

    always #5 clk = ~clk;

    noc_mux_arbiter #(
        .FLIT_WIDTH (FW),
        .CHANNELS   (CH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant)
    );

    // Scoreboard: every output handshake must match the next expected flit.
    always @(negedge clk) begin
        if (sb_en && !rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_extra: got last=%b flit=%h, required no flit", out_last, out_flit);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_last, out_flit} !== mon_e) begin
                    failures++;
                    $display("FAIL sb_flit: got last=%b flit=%h, required last=%b flit=%h",
                             out_last, out_flit, mon_e[FW], mon_e[FW-1:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_pkt(input int ch, input logic [FW-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            src_q.push_back('{ch: ch, flit: base + FW'(k), last: (k == n - 1)});
        end
    endtask

    task automatic src_drive();
        in_valid = '0;
        in_last  = '0;
        in_flit  = '0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < src_q.size(); k++) begin
                if (src_q[k].ch == c) begin
                    in_valid[c] = 1'b1;
                    in_flit[c]  = src_q[k].flit;
                    in_last[c]  = src_q[k].last;
                    break;
                end
            end
        end
    endtask

    // Called at the negedge: records accepted flits, advances to posedge+1.
    task automatic tick();
        logic [CH-1:0] fired;
        fired = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            if (fired[c]) begin
                for (int k = 0; k < src_q.size(); k++) begin
                    if (src_q[k].ch == c) begin
                        src_q.delete(k);
                        break;
                    end
                end
            end
        end
        src_drive();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        sb_en     = 1'b0;
        out_ready = 1'b1;
        src_q.delete();
        exp_q.delete();
        src_drive();
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        sb_en = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d flits still expected, required 0", name, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b1;
        sb_en     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 3'b111;
        in_last   = 3'b111;
        in_flit   = {32'hC, 32'hB, 32'hA};
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks += 3;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
            if (in_ready !== 3'b000) begin failures++; $display("FAIL rst_in_ready: got %b, required 000", in_ready); end
            if (grant !== 3'b000) begin failures++; $display("FAIL rst_grant: got %b, required 000", grant); end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 3'b001) begin failures++; $display("FAIL rst_first_grant: got %b, required 001", grant); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_contention();
        logic [8:0]    v_pat;
        logic [CH-1:0] g_exp [9];
        do_reset();
        v_pat = 9'b011011011;
        g_exp = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000};
        push_pkt(0, 32'hA0, 2);
        push_pkt(1, 32'hB0, 2);
        push_pkt(2, 32'hC0, 2);
        exp_q.push_back({1'b0, 32'hA0}); exp_q.push_back({1'b1, 32'hA1});
        exp_q.push_back({1'b0, 32'hB0}); exp_q.push_back({1'b1, 32'hB1});
        exp_q.push_back({1'b0, 32'hC0}); exp_q.push_back({1'b1, 32'hC1});
        src_drive();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks += 2;
            if (out_valid !== v_pat[c]) begin
                failures++;
                $display("FAIL cont_valid c%0d: got %b, required %b", c, out_valid, v_pat[c]);
            end
            if (grant !== g_exp[c]) begin
                failures++;
                $display("FAIL cont_grant c%0d: got %b, required %b", c, grant, g_exp[c]);
            end
            tick();
        end
        // Pointer left on ch2, so channel 0 must win next.
        push_pkt(0, 32'hD0, 1);
        push_pkt(1, 32'hD1, 1);
        push_pkt(2, 32'hD2, 1);
        exp_q.push_back({1'b1, 32'hD0});
        exp_q.push_back({1'b1, 32'hD1});
        exp_q.push_back({1'b1, 32'hD2});
        src_drive();
        @(negedge clk);
        checks++;
        if (grant !== 3'b001) begin failures++; $display("FAIL cont_ptr_grant: got %b, required 001", grant); end
        tick();
        drain("cont");
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        push_pkt(1, 32'h11, 1);
        exp_q.push_back({1'b1, 32'h11});
        src_drive();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                push_pkt(0, 32'h22, 1);
                exp_q.push_back({1'b1, 32'h22});
                src_drive();
            end
            @(negedge clk);
            checks += 4;
            if (grant !== 3'b010) begin failures++; $display("FAIL bp_grant c%0d: got %b, required 010", c, grant); end
            if (out_flit !== 32'h11) begin failures++; $display("FAIL bp_flit c%0d: got %h, required 11", c, out_flit); end
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid c%0d: got %b, required 1", c, out_valid); end
            if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL bp_ready0 c%0d: got %b, required 0", c, in_ready[0]); end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 3'b010) begin failures++; $display("FAIL bp_release_ready: got %b, required 010", in_ready); end
        tick();
        drain("bp");
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push_pkt(0, 32'h100 + k, 1);
            push_pkt(2, 32'h300 + k, 1);
            exp_q.push_back({1'b1, 32'h100 + k});
            exp_q.push_back({1'b1, 32'h300 + k});
        end
        src_drive();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (grant !== ((c % 2 == 0) ? 3'b001 : 3'b100)) begin
                failures++;
                $display("FAIL fair_grant c%0d: got %b, required %b", c, grant,
                         (c % 2 == 0) ? 3'b001 : 3'b100);
            end
            tick();
        end
        drain("fair");
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_pkt(2, 32'h40, 4);
        exp_q.push_back({1'b0, 32'h40});
        exp_q.push_back({1'b0, 32'h41});
        src_drive();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (grant !== 3'b100) begin failures++; $display("FAIL mid_grant c%0d: got %b, required 100", c, grant); end
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        checks += 3;
        if (grant !== 3'b000) begin failures++; $display("FAIL mid_rst_grant: got %b, required 000", grant); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b, required 0", out_valid); end
        if (exp_q.size() != 0) begin failures++; $display("FAIL mid_sent: %0d flits missing, required 0", exp_q.size()); end
        tick();
        rst = 1'b0;
        src_q.delete();
        exp_q.delete();
        push_pkt(0, 32'h50, 1);
        push_pkt(2, 32'h60, 1);
        exp_q.push_back({1'b1, 32'h50});
        exp_q.push_back({1'b1, 32'h60});
        src_drive();
        @(negedge clk);
        checks += 2;
        if (grant !== 3'b001) begin failures++; $display("FAIL mid_after_grant: got %b, required 001", grant); end
        if (out_flit !== 32'h50) begin failures++; $display("FAIL mid_after_flit: got %h, required 50", out_flit); end
        tick();
        drain("mid");
    endtask

    task automatic test_stream();
        do_reset();
        push_pkt(0, 32'h700, 10);
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back({(k == 9), 32'h700 + k});
        end
        for (int c = 0; c < 10; c++) begin
            out_ready = (c >= 4) ? 1'b1 : ((c % 2) == 0);
            if (c == 0) src_drive();
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (out_valid !== FIRST_VALID) begin
                    failures++;
                    $display("FAIL stream_latency: got out_valid=%b, required %b", out_valid, FIRST_VALID);
                end
            end else if (c == 1 || c >= 4) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_valid c%0d: got %b, required 1", c, out_valid);
                end
            end
            tick();
        end
        out_ready = 1'b1;
        drain("stream");
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_flit   = '0;
        @(posedge clk);
        #1;
        test_reset();
`ifndef NOC_MUX_ARBITER_OUT_REG_EN
        test_contention();
        test_backpressure();
        test_fairness();
        test_mid_reset();
`endif
        test_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_noc_mux_arbiter
`default_nettype wire
